vga_sync_decoder: RTL and testbench

- Receiver end of the 640x480 VGA timing interface.
- Samples active-low h_sync/v_sync from an external or looped-back source, regenerates the 25 MHz pixel tick, and recovers the pixel position (xpos/ypos, active).
- Measures line and frame lengths and runs a lock state machine.
- Sits between a sync source and capture/overlay logic that needs pixel coordinates without access to the generator's counters.

---
 rtl/vga_pkg.sv | 16 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/vga_sync_decoder.sv | 164 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants and the lock-state encoding used by the
// VGA sync decoder.
package vga_pkg;

  localparam int HACT  = 640;
  localparam int VACT  = 480;
  localparam int H_OFS = 144;
  localparam int V_OFS = 35;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an active-low sync pin plus a falling-edge
// detector that only compares samples on pixel-tick cycles.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic din,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Idle level of a sync pin is high, so every stage resets to 1 to avoid a
  // false edge right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      if (pix_en) prev <= sync;
    end
  end

  assign fall = pix_en & prev & ~sync;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position, line/frame lengths and a lock indication from
// externally supplied active-low h_sync/v_sync at a 25 MHz pixel rate.
module vga_sync_decoder #(
  parameter int HACT        = vga_pkg::HACT,
  parameter int VACT        = vga_pkg::VACT,
  parameter int H_OFS       = vga_pkg::H_OFS,
  parameter int V_OFS       = vga_pkg::V_OFS,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 CLK_50M,
  input  logic                 RESET,
  input  logic                 h_sync,
  input  logic                 v_sync,
  output logic [9:0]           xpos,
  output logic [9:0]           ypos,
  output logic                 active,
  output logic                 frame_start,
  output logic                 locked,
  output logic [9:0]           h_total,
  output logic [9:0]           v_total,
  output vga_pkg::lock_state_t state
);

  import vga_pkg::*;

  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [9:0] H_LO    = 10'(H_OFS);
  localparam logic [9:0] H_HI    = 10'(H_OFS + HACT);
  localparam logic [9:0] V_LO    = 10'(V_OFS);
  localparam logic [9:0] V_HI    = 10'(V_OFS + VACT);
  localparam logic [2:0] LOCK_N  = 3'(LOCK_FRAMES);

  logic        pix_en;
  logic        hs_fall;
  logic        vs_fall;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        h_act;
  logic        v_act;
  logic        timeout;
  logic        same;
  lock_state_t state_n;
  logic [9:0]  ref_h, ref_h_n;
  logic [9:0]  ref_v, ref_v_n;
  logic [2:0]  match_cnt, match_n;

  always_ff @(posedge CLK_50M or posedge RESET) begin
    if (RESET) pix_en <= 1'b0;
    else       pix_en <= ~pix_en;
  end

  sync_edge_det u_hs (
    .clk    (CLK_50M),
    .rst    (RESET),
    .pix_en (pix_en),
    .din    (h_sync),
    .fall   (hs_fall)
  );

  sync_edge_det u_vs (
    .clk    (CLK_50M),
    .rst    (RESET),
    .pix_en (pix_en),
    .din    (v_sync),
    .fall   (vs_fall)
  );

  // A line boundary coinciding with the frame boundary is absorbed by the
  // v_cnt clear, so line 0 of the new frame starts at zero.
  always_ff @(posedge CLK_50M or posedge RESET) begin
    if (RESET) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_total <= '0;
      v_total <= '0;
    end else if (pix_en) begin
      if (hs_fall) begin
        h_total <= h_cnt + 10'd1;
        h_cnt   <= '0;
      end else if (h_cnt != CNT_MAX) begin
        h_cnt <= h_cnt + 10'd1;
      end
      if (vs_fall) begin
        v_total <= v_cnt;
        v_cnt   <= '0;
      end else if (hs_fall && v_cnt != CNT_MAX) begin
        v_cnt <= v_cnt + 10'd1;
      end
    end
  end

  assign h_act = (h_cnt >= H_LO) && (h_cnt < H_HI);
  assign v_act = (v_cnt >= V_LO) && (v_cnt < V_HI);

  always_ff @(posedge CLK_50M or posedge RESET) begin
    if (RESET) begin
      xpos        <= '0;
      ypos        <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      xpos        <= h_act ? h_cnt - H_LO : 10'd0;
      ypos        <= v_act ? v_cnt - V_LO : 10'd0;
      active      <= h_act & v_act;
      frame_start <= vs_fall;
    end
  end

  // The candidate frame is the v_cnt being latched now together with the
  // line length already held in h_total.
  assign timeout = (h_cnt == CNT_MAX) || (v_cnt == CNT_MAX);
  assign same    = (v_cnt == ref_v) && (h_total == ref_h);

  always_ff @(posedge CLK_50M or posedge RESET) begin
    if (RESET) begin
      state     <= SEARCH;
      ref_h     <= '0;
      ref_v     <= '0;
      match_cnt <= '0;
    end else begin
      state     <= state_n;
      ref_h     <= ref_h_n;
      ref_v     <= ref_v_n;
      match_cnt <= match_n;
    end
  end

  always_comb begin
    state_n = state;
    ref_h_n = ref_h;
    ref_v_n = ref_v;
    match_n = match_cnt;
    if (timeout) begin
      state_n = SEARCH;
      match_n = '0;
    end else if (vs_fall) begin
      case (state)
        SEARCH: begin
          ref_h_n = h_total;
          ref_v_n = v_cnt;
          match_n = '0;
          state_n = VERIFY;
        end
        VERIFY: begin
          if (same) begin
            match_n = match_cnt + 3'd1;
            if (match_n == LOCK_N) state_n = LOCKED;
          end else begin
            ref_h_n = h_total;
            ref_v_n = v_cnt;
            match_n = '0;
          end
        end
        LOCKED: begin
          if (!same) state_n = SEARCH;
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a scaled-down raster: 16-tick lines with
// h_sync low on ticks 10-11, 12-line frames with v_sync low on lines 7-8.
module tb_vga_sync_decoder;

  import vga_pkg::*;

  localparam int T_HACT    = 8;
  localparam int T_VACT    = 6;
  localparam int T_HOFS    = 6;   // line length minus h_sync start
  localparam int T_VOFS    = 5;   // frame lines minus v_sync start line
  localparam int HS_AT     = 10;
  localparam int HS_W      = 2;
  localparam int V_LINES   = 12;
  localparam int VS_AT     = 7;
  localparam int VS_W      = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_sync;
  logic        v_sync;
  logic [9:0]  xpos;
  logic [9:0]  ypos;
  logic        active;
  logic        frame_start;
  logic        locked;
  logic [9:0]  h_total;
  logic [9:0]  v_total;
  lock_state_t state;

  int checks = 0;
  int errors = 0;

  // {locked, h_total, v_total} expected at each frame_start
  logic [20:0] exp_q[$];
  // {active, ypos, xpos} expected at each active edge while pos_chk is set
  logic [20:0] pos_q[$];
  bit          pos_chk = 1'b0;

  vga_sync_decoder #(
    .HACT        (T_HACT),
    .VACT        (T_VACT),
    .H_OFS       (T_HOFS),
    .V_OFS       (T_VOFS),
    .LOCK_FRAMES (2)
  ) dut (
    .CLK_50M     (clk),
    .RESET       (rst),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .xpos        (xpos),
    .ypos        (ypos),
    .active      (active),
    .frame_start (frame_start),
    .locked      (locked),
    .h_total     (h_total),
    .v_total     (v_total),
    .state       (state)
  );

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_xpos"},        32'(xpos),        0);
    check({tag, "_ypos"},        32'(ypos),        0);
    check({tag, "_active"},      32'(active),      0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
    check({tag, "_locked"},      32'(locked),      0);
    check({tag, "_h_total"},     32'(h_total),     0);
    check({tag, "_v_total"},     32'(v_total),     0);
    check({tag, "_state"},       32'(state),       32'(SEARCH));
  endtask

  function automatic logic [20:0] fr(input logic l, input int h, input int v);
    return {l, 10'(h), 10'(v)};
  endfunction

  // ---------------- drivers ----------------
  task automatic pix(input logic hs, input logic vs);
    h_sync = hs;
    v_sync = vs;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // vs_mode: 0 = v_sync held high, 1 = falls at line start, 2 = falls with h_sync
  task automatic run_frame(input int len, input int vs_mode, input bit pos,
                           input int rst_line, input logic [20:0] exp);
    logic hs, vs;
    for (int line = 0; line < V_LINES; line++) begin
      if (pos && line == 0) pos_chk = 1'b1;
      if (pos && line < T_VACT) begin
        pos_q.push_back({1'b1, 10'(line), 10'd0});
        pos_q.push_back({1'b1, 10'(line), 10'(T_HACT - 1)});
        pos_q.push_back({1'b0, 10'(line), 10'd0});
      end
      if (vs_mode != 0 && line == VS_AT) exp_q.push_back(exp);
      for (int t = 0; t < len; t++) begin
        if (line == rst_line && t == 3) mid_reset();
        hs = !(t >= HS_AT && t < HS_AT + HS_W);
        vs = 1'b1;
        if (vs_mode == 1 && line >= VS_AT && line < VS_AT + VS_W) vs = 1'b0;
        if (vs_mode == 2 && ((line == VS_AT && t >= HS_AT) || line == VS_AT + 1)) vs = 1'b0;
        pix(hs, vs);
      end
      if (pos && line == T_VACT) pos_chk = 1'b0;
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  logic fs_prev = 1'b0;

  always @(negedge clk) begin : frame_mon
    logic [20:0] e;
    if (frame_start) begin
      check("frame_start_width", 32'(fs_prev), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_start_unexpected: got pulse expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("frame_locked",  32'(locked),  32'(e[20]));
        check("frame_h_total", 32'(h_total), 32'(e[19:10]));
        check("frame_v_total", 32'(v_total), 32'(e[9:0]));
      end
    end
    fs_prev <= frame_start;
  end

  task automatic pos_pop_check(input string name, input logic [20:0] got);
    logic [20:0] e;
    if (pos_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected: got edge expected none (t=%0t)", name, $time);
    end else begin
      e = pos_q.pop_front();
      check({name, "_active"}, 32'(got[20]),    32'(e[20]));
      check({name, "_ypos"},   32'(got[19:10]), 32'(e[19:10]));
      check({name, "_xpos"},   32'(got[9:0]),   32'(e[9:0]));
    end
  endtask

  logic [20:0] prev_pos = '0;

  always @(negedge clk) begin : pos_mon
    logic [20:0] cur;
    cur = {active, ypos, xpos};
    if (pos_chk && cur[20] && !prev_pos[20]) begin
      pos_pop_check("pos_first", cur);
    end else if (pos_chk && !cur[20] && prev_pos[20]) begin
      pos_pop_check("pos_last", prev_pos);
      pos_pop_check("pos_after", cur);
    end
    prev_pos <= cur;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    h_sync = 1'b1;
    v_sync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Acquire: first frame is a partial count since reset (7 lines)
    run_frame(16, 1, 1'b0, -1, fr(1'b0, 16, 7));
    run_frame(16, 1, 1'b0, -1, fr(1'b0, 16, 12));
    run_frame(16, 1, 1'b0, -1, fr(1'b0, 16, 12));
    run_frame(16, 1, 1'b0, -1, fr(1'b1, 16, 12));

    // Position recovery while locked
    run_frame(16, 1, 1'b1, -1, fr(1'b1, 16, 12));

    // v_sync held high until v_cnt saturates
    for (int f = 0; f < 86; f++) run_frame(16, 0, 1'b0, -1, '0);
    check("timeout_locked", 32'(locked), 0);
    check("timeout_state",  32'(state),  32'(SEARCH));

    // Restore v_sync: saturated edge is swallowed by the timeout
    run_frame(16, 1, 1'b0, -1, fr(1'b0, 16, 1023));
    run_frame(16, 1, 1'b0, -1, fr(1'b0, 16, 12));
    run_frame(16, 1, 1'b0, -1, fr(1'b0, 16, 12));
    run_frame(16, 1, 1'b0, -1, fr(1'b1, 16, 12));

    // Line length change 16 -> 17
    run_frame(17, 1, 1'b0, -1, fr(1'b0, 17, 12));
    run_frame(17, 1, 1'b0, -1, fr(1'b0, 17, 12));
    run_frame(17, 1, 1'b0, -1, fr(1'b0, 17, 12));
    run_frame(17, 1, 1'b0, -1, fr(1'b1, 17, 12));

    // Reset mid-line on line 2, then reacquire
    run_frame(16, 1, 1'b0, 2, fr(1'b0, 16, 5));
    run_frame(16, 1, 1'b0, -1, fr(1'b0, 16, 12));
    run_frame(16, 1, 1'b0, -1, fr(1'b0, 16, 12));

    // h_sync and v_sync fall together: that line is not counted
    run_frame(16, 2, 1'b0, -1, fr(1'b1, 16, 12));
    run_frame(16, 1, 1'b0, -1, fr(1'b0, 16, 11));
    run_frame(16, 1, 1'b0, -1, fr(1'b0, 16, 12));

    repeat (40) @(posedge clk);
    #1;
    check("frames_outstanding",    32'(exp_q.size()), 0);
    check("positions_outstanding", 32'(pos_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
